psdu_byte_packer: RTL and testbench
===================================

# psdu_byte_packer

Downstream neighbour of the 802.11a receiver: takes the descrambled serial PSDU bit stream and the decoded SIGNAL LENGTH, packs bits into octets, and buffers them in a small FIFO. It presents the octets on a valid/ready byte interface with a last-byte marker. It also reports frame completion and buffer overflow to the MAC side.

## Interface
- DEPTH, 16, FIFO depth in octets; power of two, ≥2
- LEN_W, 12, width of LENGTH field (octets per PSDU)
- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- FrameStart  in  1  one-cycle pulse; Length is valid this cycle
- Length  in  LEN_W  PSDU length in octets
- BitIn  in  1  descrambled PSDU bit
- BitValid  in  1  BitIn qualifier, one bit per asserted cycle
- ByteOut  out  8  FIFO head octet
- ByteValid  out  1  FIFO non-empty
- ByteReady  in  1  consumer accepts the head octet
- ByteLast  out  1  head octet is the final octet of the frame
- Busy  out  1  high in PACK and DRAIN
- FrameDone  out  1  one-cycle pulse at frame completion
- Overflow  out  1  sticky: an octet was dropped because the FIFO was full

## Operation
- Reset values: ByteOut=0, ByteValid=0, ByteLast=0, Busy=0, FrameDone=0, Overflow=0. Reset also sets the FSM to IDLE, the FIFO to empty, and all counters to 0.
- FSM states: IDLE, PACK, DRAIN.
- IDLE
  - FrameStart with Length≠0: latch Length, clear bit_cnt/byte_cnt, clear Overflow, go to PACK.
  - FrameStart with Length=0: pulse FrameDone next cycle, stay IDLE.
  - BitValid is ignored.
- PACK
  - Each BitValid writes BitIn into shift register position bit_cnt (3-bit), LSB-first: the first bit received becomes bit 0.
  - When bit_cnt wraps 7→0, push the octet with last = (byte_cnt == Length−1), then increment byte_cnt (LEN_W bits).
  - After the push with last=1, go to DRAIN. Bits arriving after that are ignored.
- DRAIN: wait until the FIFO is empty, then pulse FrameDone and go to IDLE.
- FrameStart outside IDLE is ignored; the current frame is not disturbed.
- Push rule: a push is accepted when the FIFO is not full, or when a pop happens in the same cycle.
  - Otherwise the octet is dropped and Overflow is set.
  - byte_cnt still increments on a drop, so frame framing is preserved.
- If the dropped octet is the last one, the FSM still goes to DRAIN.
- Pop: happens when ByteValid && ByteReady. ByteOut and ByteLast are stable while ByteValid=1 and ByteReady=0.
- FIFO pointers are log2(DEPTH)+1 bits wide. Full/empty are detected by MSB-differs / all-equal comparison; pointers wrap naturally.

## Timing
- Latency: if the 8th bit of an octet is sampled at edge N, ByteValid=1 is visible after edge N+1. The FIFO is show-ahead with registered storage.
- Throughput: one octet per 8 BitValid cycles in, up to one octet per cycle out.
- FrameDone is asserted for exactly one cycle: the cycle after the final pop, observed in DRAIN with the FIFO empty.
- Busy rises in the cycle after FrameStart is accepted and falls together with the FrameDone pulse.
- Simultaneous push and pop on an empty FIFO: the pop is invalid (ByteValid=0) and the push succeeds.
- Reset asserted mid-frame clears all state immediately. Partial octets and buffered octets are discarded.

## Configuration
- PSDU_PACKER_MSB_FIRST_EN
  - Defined: the first received bit lands in bit 7 (MSB-first packing).
  - Undefined (default): LSB-first, per 802.11a bit order.
- No other behaviour changes with the macro.

## Structure
- Shared package psdu_pkg holds:
  - the FSM state type (IDLE/PACK/DRAIN)
  - BYTE_W=8
  - the default LEN_W=12, matching the SIGNAL LENGTH field
- Sub-module byte_fifo: parameterised DEPTH×(8+1) show-ahead FIFO (octet plus last flag) with push/pop/full/empty.
- The packing shift register, counters and FSM live in psdu_byte_packer.

## Test plan
- Single octet: FrameStart with Length=1, bits 1,0,1,0,0,0,0,0 with ByteReady=1 → ByteOut=8'h05 with ByteLast=1; FrameDone one cycle after the pop.
- Zero length: FrameStart with Length=0 → FrameDone pulse next cycle; Busy stays 0; no ByteValid.
- Backpressure: Length=20, ByteReady=0 throughout, DEPTH=16 → 16 octets held; Overflow=1 at the 17th octet; FrameDone only after the consumer drains 16 octets. The final held octet has ByteLast=0 because the last octet was dropped.
- Full FIFO with simultaneous pop: FIFO full and ByteReady=1 in the same cycle the 8th bit completes → push accepted; Overflow stays 0.
- Reset mid-frame: Reset low after 3 octets of Length=10 → all outputs return to reset values; the next FrameStart with Length=2 produces exactly 2 correct octets.
- MSB-first build: with PSDU_PACKER_MSB_FIRST_EN defined, bits 1,0,1,0,0,0,0,0 → ByteOut=8'hA0.

Source files
------------

// File: rtl/psdu_pkg.sv
// Shared types and constants for the PSDU byte packer slice.
package psdu_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_LEN_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DRAIN
  } state_t;

endpackage

// File: rtl/psdu_byte_packer_byte_fifo.sv
// Show-ahead FIFO of DEPTH entries, each an octet plus its last-of-frame flag.
module byte_fifo
  import psdu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_push_data,
  input  logic              i_push_last,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head_data,
  output logic              o_head_last,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [BYTE_W:0] r_mem [DEPTH];
  logic [BYTE_W:0] w_head;
  logic            w_pop_ok;
  logic            w_push_ok;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= {i_push_last, i_push_data};
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign o_head_data = o_empty ? '0 : w_head[BYTE_W-1:0];
  assign o_head_last = o_empty ? 1'b0 : w_head[BYTE_W];

endmodule

// File: rtl/psdu_byte_packer.sv
// Packs the descrambled PSDU bit stream into octets and buffers them for the MAC.
// Define PSDU_PACKER_MSB_FIRST_EN to pack the first received bit into bit 7.
module psdu_byte_packer
  import psdu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic [LEN_W-1:0]  i_length,
  input  logic              i_bit_in,
  input  logic              i_bit_valid,
  output logic [BYTE_W-1:0] o_byte_out,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic              o_byte_last,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overflow
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_bit_cnt;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic [LEN_W-1:0]  r_length;
  logic [BYTE_W-1:0] r_shift;
  logic              r_push_vld;
  logic [BYTE_W-1:0] r_push_data;
  logic              r_push_last;
  logic              r_frame_done;
  logic              r_overflow;

  logic [2:0]        w_bit_idx;
  logic [BYTE_W-1:0] w_octet;
  logic              w_octet_done;
  logic              w_is_last;
  logic              w_frame_done_nxt;
  logic              w_accept_start;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_drop;

`ifdef PSDU_PACKER_MSB_FIRST_EN
  assign w_bit_idx = 3'd7 - r_bit_cnt;
`else
  assign w_bit_idx = r_bit_cnt;
`endif

  assign w_accept_start = (r_state == IDLE) && i_frame_start && (i_length != '0);
  assign w_octet_done   = (r_state == PACK) && i_bit_valid && (r_bit_cnt == 3'd7);
  assign w_is_last      = (r_byte_cnt == (r_length - LEN_W'(1)));
  assign w_pop          = o_byte_valid && i_byte_ready;
  assign w_drop         = r_push_vld && w_fifo_full && !w_pop;

  always_comb begin
    w_octet            = r_shift;
    w_octet[w_bit_idx] = i_bit_in;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // DRAIN must also wait for the octet still in the push register.
  always_comb begin
    w_state_nxt      = r_state;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_frame_start) begin
          if (i_length != '0) w_state_nxt      = PACK;
          else                w_frame_done_nxt = 1'b1;
        end
      end
      PACK: begin
        if (w_octet_done && w_is_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_fifo_empty && !r_push_vld) begin
          w_state_nxt      = IDLE;
          w_frame_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_length     <= '0;
      r_shift      <= '0;
      r_push_vld   <= 1'b0;
      r_push_data  <= '0;
      r_push_last  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_push_vld   <= 1'b0;
      r_frame_done <= w_frame_done_nxt;
      if (w_accept_start) begin
        r_length   <= i_length;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_overflow <= 1'b0;
      end
      if ((r_state == PACK) && i_bit_valid) begin
        r_shift[w_bit_idx] <= i_bit_in;
        r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
      // Dropped octets still advance byte_cnt so the last marker stays aligned.
      if (w_octet_done) begin
        r_push_vld  <= 1'b1;
        r_push_data <= w_octet;
        r_push_last <= w_is_last;
        r_byte_cnt  <= r_byte_cnt + LEN_W'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_push_vld),
    .i_push_data (r_push_data),
    .i_push_last (r_push_last),
    .i_pop       (w_pop),
    .o_head_data (o_byte_out),
    .o_head_last (o_byte_last),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign o_byte_valid = !w_fifo_empty;
  assign o_busy       = (r_state != IDLE);
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_psdu_byte_packer.sv
// Directed bench for psdu_byte_packer; expected octets follow PSDU_PACKER_MSB_FIRST_EN.
module tb_psdu_byte_packer;

  logic        clk;
  logic        rstN;
  logic        frameStart;
  logic [11:0] length;
  logic        bitIn;
  logic        bitValid;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        byteReady;
  logic        byteLast;
  logic        busy;
  logic        frameDone;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  psdu_byte_packer #(
    .DEPTH(16),
    .LEN_W(12)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_frame_start(frameStart),
    .i_length     (length),
    .i_bit_in     (bitIn),
    .i_bit_valid  (bitValid),
    .o_byte_out   (byteOut),
    .o_byte_valid (byteValid),
    .i_byte_ready (byteReady),
    .o_byte_last  (byteLast),
    .o_busy       (busy),
    .o_frame_done (frameDone),
    .o_overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected octet for a bit sequence whose element 0 arrives first.
  function automatic logic [7:0] expOctet(input logic [7:0] seq);
    logic [7:0] r;
`ifdef PSDU_PACKER_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = seq[7-i];
`else
    r = seq;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".byteOut"},   32'(byteOut),   32'h0);
    checkOutput({tag, ".byteValid"}, 32'(byteValid), 32'h0);
    checkOutput({tag, ".byteLast"},  32'(byteLast),  32'h0);
    checkOutput({tag, ".busy"},      32'(busy),      32'h0);
    checkOutput({tag, ".frameDone"}, 32'(frameDone), 32'h0);
    checkOutput({tag, ".overflow"},  32'(overflow),  32'h0);
  endtask

  task automatic applyStimulus(input logic [11:0] len);
    frameStart = 1'b1;
    length     = len;
    tick();
    frameStart = 1'b0;
  endtask

  // Sends seq[0] first; bitValid drops after the eighth bit.
  task automatic sendBits(input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      bitValid = 1'b1;
      bitIn    = seq[i];
      tick();
    end
    bitValid = 1'b0;
    bitIn    = 1'b0;
  endtask

  initial begin
    rstN       = 1'b0;
    frameStart = 1'b0;
    length     = '0;
    bitIn      = 1'b0;
    bitValid   = 1'b0;
    byteReady  = 1'b0;
    #12;
    checkResetOutputs("reset");
    rstN = 1'b1;
    tick();

    // Single octet, consumer always ready.
    byteReady = 1'b1;
    applyStimulus(12'd1);
    checkOutput("single.busy", 32'(busy), 32'h1);
    sendBits(8'h05);
    checkOutput("single.latency", 32'(byteValid), 32'h0);
    tick();
    checkOutput("single.valid", 32'(byteValid), 32'h1);
    checkOutput("single.byte",  32'(byteOut),   32'(expOctet(8'h05)));
    checkOutput("single.last",  32'(byteLast),  32'h1);
    tick();
    checkOutput("single.popped", 32'(byteValid), 32'h0);
    checkOutput("single.doneEarly", 32'(frameDone), 32'h0);
    checkOutput("single.busyDrain", 32'(busy), 32'h1);
    tick();
    checkOutput("single.done", 32'(frameDone), 32'h1);
    checkOutput("single.busyFall", 32'(busy), 32'h0);
    tick();
    checkOutput("single.donePulse", 32'(frameDone), 32'h0);
    byteReady = 1'b0;

    // Zero length frame.
    applyStimulus(12'd0);
    checkOutput("zero.done", 32'(frameDone), 32'h1);
    checkOutput("zero.busy", 32'(busy), 32'h0);
    checkOutput("zero.valid", 32'(byteValid), 32'h0);
    tick();
    checkOutput("zero.donePulse", 32'(frameDone), 32'h0);

    // Backpressure: 20 octets into a 16-deep FIFO, last four dropped.
    applyStimulus(12'd20);
    for (int k = 0; k < 16; k++) sendBits(8'h10 + 8'(k));
    tick();
    checkOutput("bp.noOvfAt16", 32'(overflow), 32'h0);
    sendBits(8'h20);
    tick();
    checkOutput("bp.ovfAt17", 32'(overflow), 32'h1);
    for (int k = 17; k < 20; k++) sendBits(8'h10 + 8'(k));
    tick();
    checkOutput("bp.busyDrain", 32'(busy), 32'h1);
    frameStart = 1'b1;
    length     = 12'd0;
    tick();
    frameStart = 1'b0;
    tick();
    checkOutput("bp.startIgnored", 32'(frameDone), 32'h0);
    checkOutput("bp.stillBusy", 32'(busy), 32'h1);
    byteReady = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("bp.valid%0d", k), 32'(byteValid), 32'h1);
      checkOutput($sformatf("bp.byte%0d", k),  32'(byteOut),   32'(expOctet(8'h10 + 8'(k))));
      checkOutput($sformatf("bp.last%0d", k),  32'(byteLast),  32'h0);
      tick();
    end
    byteReady = 1'b0;
    checkOutput("bp.empty", 32'(byteValid), 32'h0);
    checkOutput("bp.doneEarly", 32'(frameDone), 32'h0);
    tick();
    checkOutput("bp.done", 32'(frameDone), 32'h1);
    checkOutput("bp.busyFall", 32'(busy), 32'h0);
    checkOutput("bp.ovfSticky", 32'(overflow), 32'h1);

    // Full FIFO with a pop in the push cycle: no drop.
    applyStimulus(12'd17);
    checkOutput("full.ovfCleared", 32'(overflow), 32'h0);
    for (int k = 0; k < 16; k++) sendBits(8'h40 + 8'(k));
    sendBits(8'h50);
    byteReady = 1'b1;
    tick();
    byteReady = 1'b0;
    checkOutput("full.noOvf", 32'(overflow), 32'h0);
    byteReady = 1'b1;
    for (int k = 1; k < 17; k++) begin
      checkOutput($sformatf("full.byte%0d", k), 32'(byteOut),  32'(expOctet(8'h40 + 8'(k))));
      checkOutput($sformatf("full.last%0d", k), 32'(byteLast), 32'(k == 16));
      tick();
    end
    byteReady = 1'b0;
    checkOutput("full.empty", 32'(byteValid), 32'h0);
    tick();
    checkOutput("full.done", 32'(frameDone), 32'h1);
    checkOutput("full.ovfFinal", 32'(overflow), 32'h0);

    // Reset mid-frame, then a clean two-octet frame.
    applyStimulus(12'd10);
    for (int k = 0; k < 3; k++) sendBits(8'h77 + 8'(k));
    bitValid = 1'b1;
    bitIn    = 1'b1;
    tick();
    tick();
    bitValid = 1'b0;
    rstN     = 1'b0;
    #1;
    checkResetOutputs("midReset");
    tick();
    rstN = 1'b1;
    tick();
    applyStimulus(12'd2);
    sendBits(8'hC3);
    sendBits(8'h5A);
    tick();
    checkOutput("rst2.valid0", 32'(byteValid), 32'h1);
    checkOutput("rst2.byte0",  32'(byteOut),   32'(expOctet(8'hC3)));
    checkOutput("rst2.last0",  32'(byteLast),  32'h0);
    byteReady = 1'b1;
    tick();
    checkOutput("rst2.byte1",  32'(byteOut),   32'(expOctet(8'h5A)));
    checkOutput("rst2.last1",  32'(byteLast),  32'h1);
    tick();
    byteReady = 1'b0;
    checkOutput("rst2.empty", 32'(byteValid), 32'h0);
    tick();
    checkOutput("rst2.done", 32'(frameDone), 32'h1);
    checkOutput("rst2.noOvf", 32'(overflow), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
